tag_stream_collector: RTL and testbench

- Sits directly downstream of the multi-stream HEVC datapath's tagged out_port write interface.
- Accepts tagged tokens of {tag, data} and buffers each tag in its own FIFO.
- Gives per-tag back-pressure through a FLUX-wide full vector.
- Drains the FIFOs onto a single tagged write interface toward the sink, using round-robin arbitration so no stream starves.

---
 rtl/tag_stream_collector.sv | 131 +++++++++++++
 tb/tb_tag_stream_collector.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/tag_stream_collector.sv
// Per-tag FIFO collector for tagged token streams.
// Round-robin drains all tags onto one registered tagged write port.
module tag_stream_collector #(
    parameter int DEPTH      = 16,
    parameter int FLUX       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TAG_WIDTH  = $clog2(FLUX)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH+TAG_WIDTH-1:0] in_din,
    input  logic                            in_write,
    output logic [FLUX-1:0]                 in_full,
    output logic [DATA_WIDTH+TAG_WIDTH-1:0] out_din,
    output logic                            out_write,
    input  logic                            out_full,
    output logic [FLUX-1:0]                 err_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int W  = DATA_WIDTH + TAG_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [FLUX][DEPTH];
    logic [AW-1:0]         wr_q  [FLUX];
    logic [AW-1:0]         rd_q  [FLUX];
    logic [CW-1:0]         cnt_q [FLUX];
    logic [CW-1:0]         cnt_d [FLUX];
    logic [FLUX-1:0]       full_q;
    logic [FLUX-1:0]       err_q;
    logic [TAG_WIDTH-1:0]  rr_q;
    logic [W-1:0]          dout_q;
    logic                  wout_q;

    logic [TAG_WIDTH-1:0]  in_tag;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  tag_ok;
    logic                  push;
    logic                  ovf;
    logic [FLUX-1:0]       elig;
    logic                  gnt_vld;
    logic [TAG_WIDTH-1:0]  gnt;
    logic [TAG_WIDTH-1:0]  rr_nxt;

    assign in_tag  = in_din[W-1:DATA_WIDTH];
    assign in_data = in_din[DATA_WIDTH-1:0];
    assign tag_ok  = int'(in_tag) < FLUX;
    assign push    = in_write && tag_ok && !full_q[in_tag];
    assign ovf     = in_write && tag_ok && full_q[in_tag];

    always_comb begin
        for (int t = 0; t < FLUX; t++) begin
            elig[t] = cnt_q[t] != '0;
        end
    end

    // Walk downward so the lowest offset from rr_q is the last to win.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt     = '0;
        for (int i = FLUX - 1; i >= 0; i--) begin
            idx = (int'(rr_q) + i) % FLUX;
            if (!out_full && elig[idx]) begin
                gnt_vld = 1'b1;
                gnt     = TAG_WIDTH'(idx);
            end
        end
    end

    assign rr_nxt = (int'(gnt) == FLUX - 1) ? '0 : gnt + TAG_WIDTH'(1);

    always_comb begin
        for (int t = 0; t < FLUX; t++) begin
            cnt_d[t] = cnt_q[t];
            if (push && in_tag == TAG_WIDTH'(t)) begin
                cnt_d[t] = cnt_d[t] + CW'(1);
            end
            if (gnt_vld && gnt == TAG_WIDTH'(t)) begin
                cnt_d[t] = cnt_d[t] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[in_tag][wr_q[in_tag]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int t = 0; t < FLUX; t++) begin
                wr_q[t]  <= '0;
                rd_q[t]  <= '0;
                cnt_q[t] <= '0;
            end
            full_q <= '0;
            err_q  <= '0;
            rr_q   <= '0;
            dout_q <= '0;
            wout_q <= 1'b0;
        end else begin
            for (int t = 0; t < FLUX; t++) begin
                cnt_q[t]  <= cnt_d[t];
                full_q[t] <= cnt_d[t] == CW'(DEPTH);
            end
            if (push) begin
                wr_q[in_tag] <= wr_q[in_tag] + AW'(1);
            end
            if (ovf) begin
                err_q[in_tag] <= 1'b1;
            end
            if (gnt_vld) begin
                rd_q[gnt] <= rd_q[gnt] + AW'(1);
                dout_q    <= {gnt, mem_q[gnt][rd_q[gnt]]};
                wout_q    <= 1'b1;
                rr_q      <= rr_nxt;
            end else begin
                wout_q <= 1'b0;
            end
        end
    end

    assign in_full      = full_q;
    assign err_overflow = err_q;
    assign out_din      = dout_q;
    assign out_write    = wout_q;

endmodule

// File: tb/tb_tag_stream_collector.sv
// Directed and randomized bench for tag_stream_collector.
// A queue-per-tag model predicts every output each cycle.
module tb_tag_stream_collector;

    localparam int DEPTH = 16;
    localparam int FLUX  = 4;
    localparam int DW    = 8;
    localparam int TW    = 2;
    localparam int W     = DW + TW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  in_din = '0;
    logic          in_write = 1'b0;
    logic [FLUX-1:0] in_full;
    logic [W-1:0]  out_din;
    logic          out_write;
    logic          out_full = 1'b0;
    logic [FLUX-1:0] err_overflow;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] mq [FLUX][$];
    int            mrr = 0;
    logic          mwr = 1'b0;
    logic [W-1:0]  mout = '0;
    logic [FLUX-1:0] mfull = '0;
    logic [FLUX-1:0] merr = '0;
    logic [W-1:0]  outs [$];

    tag_stream_collector #(
        .DEPTH(DEPTH), .FLUX(FLUX), .DATA_WIDTH(DW), .TAG_WIDTH(TW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_din(in_din), .in_write(in_write), .in_full(in_full),
        .out_din(out_din), .out_write(out_write), .out_full(out_full),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit w, input logic [W-1:0] d,
                              input bit of);
        bit gv;
        int g;
        int tg;
        bit do_push;
        gv = 0;
        g  = 0;
        if (!of) begin
            for (int i = 0; i < FLUX; i++) begin
                if (!gv && mq[(mrr + i) % FLUX].size() > 0) begin
                    gv = 1;
                    g  = (mrr + i) % FLUX;
                end
            end
        end
        tg = int'(d[W-1:DW]);
        do_push = 0;
        if (w) begin
            if (mfull[tg]) merr[tg] = 1'b1;
            else do_push = 1;
        end
        if (gv) begin
            mout = {TW'(g), mq[g].pop_front()};
            mwr  = 1'b1;
            mrr  = (g + 1) % FLUX;
        end else begin
            mwr = 1'b0;
        end
        if (do_push) mq[tg].push_back(d[DW-1:0]);
        for (int t = 0; t < FLUX; t++) mfull[t] = mq[t].size() == DEPTH;
    endtask

    task automatic step(input bit w, input logic [W-1:0] d, input bit of);
        in_write = w;
        in_din   = d;
        out_full = of;
        @(posedge clk);
        model_edge(w, d, of);
        #1;
        check("out_write", 32'(out_write), 32'(mwr));
        check("out_din", 32'(out_din), 32'(mout));
        check("in_full", 32'(in_full), 32'(mfull));
        check("err_overflow", 32'(err_overflow), 32'(merr));
        if (out_write) outs.push_back(out_din);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_out_write", 32'(out_write), 32'h0);
        check("rst_out_din", 32'(out_din), 32'h0);
        check("rst_in_full", 32'(in_full), 32'h0);
        check("rst_err", 32'(err_overflow), 32'h0);
        for (int t = 0; t < FLUX; t++) mq[t].delete();
        mrr = 0; mwr = 1'b0; mout = '0; mfull = '0; merr = '0;
        in_write = 1'b0;
        out_full = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        outs.delete();
    endtask

    function automatic logic [W-1:0] tok(input int t, input int d);
        return {TW'(t), DW'(d)};
    endfunction

    initial begin
        logic [W-1:0] exp_rr [6];
        #2;
        do_reset();

        // single token latency
        step(1, tok(2, 8'hA5), 0);
        check("single_n", 32'(out_write), 32'h0);
        step(0, '0, 0);
        check("single_wr", 32'(out_write), 32'h1);
        check("single_din", 32'(out_din), 32'h2A5);
        step(0, '0, 0);
        check("single_once", 32'(out_write), 32'h0);

        // round robin
        do_reset();
        step(1, tok(0, 8'h10), 1); step(1, tok(0, 8'h11), 1);
        step(1, tok(1, 8'h20), 1); step(1, tok(1, 8'h21), 1);
        step(1, tok(3, 8'h30), 1); step(1, tok(3, 8'h31), 1);
        outs.delete();
        for (int i = 0; i < 6; i++) begin
            step(0, '0, 0);
            check("rr_b2b", 32'(out_write), 32'h1);
        end
        step(0, '0, 0);
        exp_rr = '{10'h010, 10'h120, 10'h330, 10'h011, 10'h121, 10'h331};
        check("rr_count", 32'(outs.size()), 32'd6);
        for (int i = 0; i < 6 && i < outs.size(); i++)
            check("rr_order", 32'(outs[i]), 32'(exp_rr[i]));

        // mid-stream reset with three tokens in tag 1
        do_reset();
        for (int i = 0; i < 3; i++) step(1, tok(1, 8'h40 + i), 1);
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 0);
            check("post_rst_idle", 32'(out_write), 32'h0);
        end

        // fill to full, then overflow
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, tok(0, i), 1);
        check("full0", 32'(in_full[0]), 32'h1);
        step(1, tok(0, 8'hFF), 1);
        check("ovf0", 32'(err_overflow[0]), 32'h1);
        outs.delete();
        for (int i = 0; i < DEPTH + 2; i++) step(0, '0, 0);
        check("drain_count", 32'(outs.size()), 32'd16);
        for (int i = 0; i < outs.size(); i++)
            check("drain_data", 32'(outs[i]), 32'(i));
        check("ovf_sticky", 32'(err_overflow[0]), 32'h1);

        // toggling back-pressure
        do_reset();
        for (int i = 0; i < 4; i++) step(1, tok(3, 8'h50 + i), 1);
        outs.delete();
        for (int i = 0; i < 10; i++) step(0, '0, i[0] == 1'b0);
        check("bp_count", 32'(outs.size()), 32'd4);
        for (int i = 0; i < 4 && i < outs.size(); i++)
            check("bp_data", 32'(outs[i]), 32'(tok(3, 8'h50 + i)));

        // continuous single-tag stream
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1, tok(1, i), 0);
            if (i >= 1) check("stream_wr", 32'(out_write), 32'h1);
            check("stream_nofull", 32'(in_full), 32'h0);
        end

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 70,
                 W'($urandom),
                 $urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 60 : 20));
        end
        for (int i = 0; i < 80; i++) step(0, '0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
